// File: rtl/mod3_pkg.sv
// mod3_pkg: shared state enum, remainder type and the divide-by-3 step table
// Optional feature macro MOD3_DEBUG_EN is consumed by mod3_serial_if and mod3_serial.
package mod3_pkg;
  typedef enum logic {IDLE, ACC} state_t;
  typedef logic [1:0] rem_t;
  // (2*r + b) mod 3 as a lookup; r==3 never occurs and maps like r==2
  function automatic rem_t step_rem(input rem_t r, input logic b);
    return r == 2'd0 ? {1'b0, b} :
           r == 2'd1 ? (b ? 2'd0 : 2'd2) :
                       (b ? 2'd2 : 2'd1);
  endfunction
endpackage

// File: rtl/mod3_serial_if.sv
// mod3_serial_if: serial operand stream and result signals of the mod-3 checker
// Signals: in/start/finish (source -> checker), out/is_out (checker -> sink).
// With MOD3_DEBUG_EN: rem_o[1:0] and len_o[LEN_W-1:0] (checker -> sink).
interface mod3_serial_if #(parameter int LEN_W = 6);
  logic in;
  logic start;
  logic finish;
  logic out;
  logic is_out;
`ifdef MOD3_DEBUG_EN
  logic [1:0] rem_o;
  logic [LEN_W-1:0] len_o;
  modport master (output in, start, finish, input out, is_out, rem_o, len_o);
  modport slave (input in, start, finish, output out, is_out, rem_o, len_o);
`else
  modport master (output in, start, finish, input out, is_out);
  modport slave (input in, start, finish, output out, is_out);
`endif
endinterface

// File: rtl/mod3_step.sv
// mod3_step: combinational remainder update, rem_next = (2*rem + in) mod 3
// Ports: rem[1:0] current remainder, in data bit, nxt[1:0] next remainder.
module mod3_step
  import mod3_pkg::*;
(
  input  rem_t rem,
  input  logic in,
  output rem_t nxt
);
  assign nxt = step_rem(rem, in);
endmodule

// File: rtl/mod3_serial.sv
// mod3_serial: bit-serial (MSB first) divisibility-by-3 checker
// Ports: clk, rst_n (async active-low), bus (mod3_serial_if.slave: in, start,
// finish, out, is_out; plus rem_o, len_o when MOD3_DEBUG_EN is defined).
// MOD3_DEBUG_EN adds the final remainder and saturating frame length outputs.
module mod3_serial
  import mod3_pkg::*;
#(
  parameter int LEN_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  mod3_serial_if.slave bus
);
  state_t state, state_n;
  rem_t rem, rem_n, nxt;
  logic out, out_n, is_out, is_out_n;
  logic accept, done;
  // a start bit seeds the step with remainder 0, so nxt equals the bit itself
  mod3_step u_step (
    .rem(bus.start ? 2'd0 : rem),
    .in (bus.in),
    .nxt(nxt)
  );
  always_comb begin
    accept   = bus.start || state == ACC;
    done     = accept && bus.finish;
    state_n  = done ? IDLE : accept ? ACC : state;
    rem_n    = accept && !done ? nxt : rem;
    out_n    = done ? nxt == 2'd0 : out;
    is_out_n = done;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= '0;
      out    <= 1'b0;
      is_out <= 1'b0;
    end else begin
      state  <= state_n;
      rem    <= rem_n;
      out    <= out_n;
      is_out <= is_out_n;
    end
  assign bus.out    = out;
  assign bus.is_out = is_out;
`ifdef MOD3_DEBUG_EN
  logic [LEN_W-1:0] len, len_n, cnt, len_o;
  rem_t rem_o;
  always_comb begin
    cnt   = bus.start ? LEN_W'(1) : len == '1 ? len : len + LEN_W'(1);
    len_n = accept ? cnt : len;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len   <= '0;
      len_o <= '0;
      rem_o <= '0;
    end else begin
      len <= len_n;
      if (done) begin
        len_o <= cnt;
        rem_o <= nxt;
      end
    end
  assign bus.rem_o = rem_o;
  assign bus.len_o = len_o;
`endif
endmodule

// File: tb/tb_mod3_serial.sv
// tb_mod3_serial: directed self-checking bench for mod3_serial
module tb_mod3_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int pulses = 0;
  mod3_serial_if #(.LEN_W(6)) bus ();
  mod3_serial #(.LEN_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic drive(input logic b, input logic s, input logic f);
    @(negedge clk);
    bus.in = b;
    bus.start = s;
    bus.finish = f;
    @(posedge clk);
    #1;
    pulses += int'(bus.is_out);
  endtask

  task automatic send_frame(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive(v[i], i == n - 1, i == 0);
  endtask

  task automatic test_reset;
    bus.in = 1'b0; bus.start = 1'b0; bus.finish = 1'b0;
    #12;
    n_checks++;
    if (bus.out !== 1'b0 || bus.is_out !== 1'b0) begin
      n_fail++; $display("FAIL reset: out=%b is_out=%b expected 0 0", bus.out, bus.is_out);
    end
`ifdef MOD3_DEBUG_EN
    n_checks++;
    if (bus.rem_o !== 2'd0 || bus.len_o !== 6'd0) begin
      n_fail++; $display("FAIL reset_dbg: rem_o=%0d len_o=%0d expected 0 0", bus.rem_o, bus.len_o);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_33;
    send_frame(128'd33, 8);
    n_checks++;
    if (bus.out !== 1'b1 || bus.is_out !== 1'b1) begin
      n_fail++; $display("FAIL frame33: out=%b is_out=%b expected 1 1", bus.out, bus.is_out);
    end
`ifdef MOD3_DEBUG_EN
    n_checks++;
    if (bus.rem_o !== 2'd0 || bus.len_o !== 6'd8) begin
      n_fail++; $display("FAIL frame33_dbg: rem_o=%0d len_o=%0d expected 0 8", bus.rem_o, bus.len_o);
    end
`endif
    drive(0, 0, 0);
    n_checks++;
    if (bus.is_out !== 1'b0 || bus.out !== 1'b1) begin
      n_fail++; $display("FAIL frame33_after: is_out=%b out=%b expected 0 1", bus.is_out, bus.out);
    end
  endtask

  task automatic test_29;
    repeat (7) drive(0, 0, 0);
    send_frame(128'd29, 8);
    n_checks++;
    if (bus.out !== 1'b0 || bus.is_out !== 1'b1) begin
      n_fail++; $display("FAIL frame29: out=%b is_out=%b expected 0 1", bus.out, bus.is_out);
    end
`ifdef MOD3_DEBUG_EN
    n_checks++;
    if (bus.rem_o !== 2'd2 || bus.len_o !== 6'd8) begin
      n_fail++; $display("FAIL frame29_dbg: rem_o=%0d len_o=%0d expected 2 8", bus.rem_o, bus.len_o);
    end
`endif
    drive(0, 0, 0);
    n_checks++;
    if (bus.is_out !== 1'b0) begin
      n_fail++; $display("FAIL frame29_after: is_out=%b expected 0", bus.is_out);
    end
  endtask

  task automatic test_long;
    send_frame('1, 70);
    n_checks++;
    if (bus.out !== 1'b1 || bus.is_out !== 1'b1) begin
      n_fail++; $display("FAIL long70: out=%b is_out=%b expected 1 1", bus.out, bus.is_out);
    end
`ifdef MOD3_DEBUG_EN
    n_checks++;
    if (bus.rem_o !== 2'd0 || bus.len_o !== 6'd63) begin
      n_fail++; $display("FAIL long70_dbg: rem_o=%0d len_o=%0d expected 0 63", bus.rem_o, bus.len_o);
    end
`endif
  endtask

  task automatic test_single;
    drive(1, 1, 1);
    n_checks++;
    if (bus.out !== 1'b0 || bus.is_out !== 1'b1) begin
      n_fail++; $display("FAIL single1: out=%b is_out=%b expected 0 1", bus.out, bus.is_out);
    end
    drive(0, 1, 1);
    n_checks++;
    if (bus.out !== 1'b1 || bus.is_out !== 1'b1) begin
      n_fail++; $display("FAIL single0: out=%b is_out=%b expected 1 1", bus.out, bus.is_out);
    end
`ifdef MOD3_DEBUG_EN
    n_checks++;
    if (bus.rem_o !== 2'd0 || bus.len_o !== 6'd1) begin
      n_fail++; $display("FAIL single0_dbg: rem_o=%0d len_o=%0d expected 0 1", bus.rem_o, bus.len_o);
    end
`endif
    drive(0, 0, 0);
    n_checks++;
    if (bus.is_out !== 1'b0) begin
      n_fail++; $display("FAIL single_after: is_out=%b expected 0", bus.is_out);
    end
  endtask

  task automatic test_idle_noise;
    pulses = 0;
    for (int i = 0; i < 10; i++) drive(i[0], 1'b0, i[1] | i[0]);
    n_checks++;
    if (pulses !== 0 || bus.out !== 1'b1) begin
      n_fail++; $display("FAIL idle_noise: pulses=%0d out=%b expected 0 1", pulses, bus.out);
    end
  endtask

  task automatic test_restart;
    pulses = 0;
    drive(1, 1, 0); drive(0, 0, 0); drive(1, 0, 0);
    send_frame(128'd6, 8);
    n_checks++;
    if (bus.out !== 1'b1 || pulses !== 1 || bus.is_out !== 1'b1) begin
      n_fail++; $display("FAIL restart: out=%b pulses=%0d is_out=%b expected 1 1 1", bus.out, pulses, bus.is_out);
    end
`ifdef MOD3_DEBUG_EN
    n_checks++;
    if (bus.rem_o !== 2'd0 || bus.len_o !== 6'd8) begin
      n_fail++; $display("FAIL restart_dbg: rem_o=%0d len_o=%0d expected 0 8", bus.rem_o, bus.len_o);
    end
`endif
  endtask

  task automatic test_mid_reset;
    logic [7:0] v;
    v = 8'd33;
    pulses = 0;
    for (int i = 7; i >= 4; i--) drive(v[i], i == 7, 1'b0);
    @(negedge clk);
    bus.in = 1'b0; bus.start = 1'b0; bus.finish = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out !== 1'b0 || bus.is_out !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: out=%b is_out=%b expected 0 0", bus.out, bus.is_out);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 3; i >= 0; i--) drive(v[i], 1'b0, i == 0);
    drive(0, 0, 0);
    n_checks++;
    if (pulses !== 0 || bus.out !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: pulses=%0d out=%b expected 0 0", pulses, bus.out);
    end
    send_frame(128'd9, 8);
    n_checks++;
    if (bus.out !== 1'b1 || bus.is_out !== 1'b1) begin
      n_fail++; $display("FAIL frame9: out=%b is_out=%b expected 1 1", bus.out, bus.is_out);
    end
  endtask

  task automatic test_back_to_back;
    send_frame(128'd29, 8);
    n_checks++;
    if (bus.out !== 1'b0 || bus.is_out !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: out=%b is_out=%b expected 0 1", bus.out, bus.is_out);
    end
    drive(0, 1, 0);
    n_checks++;
    if (bus.is_out !== 1'b0 || bus.out !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap: is_out=%b out=%b expected 0 0", bus.is_out, bus.out);
    end
    for (int i = 6; i >= 0; i--) drive(i == 5 || i == 0, 1'b0, i == 0);
    n_checks++;
    if (bus.out !== 1'b1 || bus.is_out !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: out=%b is_out=%b expected 1 1", bus.out, bus.is_out);
    end
`ifdef MOD3_DEBUG_EN
    n_checks++;
    if (bus.rem_o !== 2'd0 || bus.len_o !== 6'd8) begin
      n_fail++; $display("FAIL b2b_dbg: rem_o=%0d len_o=%0d expected 0 8", bus.rem_o, bus.len_o);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_33;
    test_29;
    test_long;
    test_single;
    test_idle_noise;
    test_restart;
    test_mid_reset;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
